id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage of the 5-stage RV32I core. Sits directly downstream of the opcode decoder.
//  Registers the decoder's 7 control signals plus operands, immediate and register indices into EX.
//  Detects load-use hazards, stalls PC/IF-ID, inserts bubbles and counts them.
//  Also applies branch flush and downstream hold.
// PARAMETERS
//  XLEN      32  datapath width (pc, rs1/rs2 data, immediate)
//  CNT_W     16  width of the saturating bubble counter
// PORTS
//  clk              in   1     single clock; all state updates on rising edge
//  rst              in   1     asynchronous, active-high reset
//  id_valid         in   1     ID holds a real instruction
//  id_pc            in   XLEN  PC of ID instruction
//  id_rs1_data      in   XLEN  register-file read port 1
//  id_rs2_data      in   XLEN  register-file read port 2
//  id_imm           in   XLEN  sign-extended immediate
//  id_rs1/id_rs2/id_rd in 5    register indices
//  id_funct3        in   3     funct3 field
//  id_funct7_b5     in   1     instr[30]
//  control_branch, control_mem_read, control_mem_to_reg, control_mem_write,
//  control_alu_src, control_reg_write   in 1 each  decoder outputs
//  control_alu_op   in   2     decoder ALU op (00 add, 01 sub/branch, 10 funct-decoded)
//  flush            in   1     branch taken in EX; kill ID instruction
//  ex_hold          in   1     downstream (MEM) stall; freeze this stage
//  stall            out  1     load-use hazard; PC and IF/ID must hold
//  ex_valid         out  1     EX slot holds a real instruction
//  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out XLEN  registered copies
//  ex_rs1, ex_rs2, ex_rd  out 5;  ex_funct3 out 3;  ex_funct7_b5 out 1
//  ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write out 1; ex_alu_op out 2
//  bubble_count     out  CNT_W bubbles inserted since reset, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): every ex_* output = 0, ex_valid=0, bubble_count=0. Released synchronously.
//  - Hazard (combinational): stall = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) &
//    (ex_rd==id_rs1 | ex_rd==id_rs2) & ~flush & ~ex_hold. x0 never hazards.
//  - Per-edge update, strict priority:
//    1 flush   -> bubble: ex_valid=0, all control outs=0, data/index fields don't-care (cleared to 0).
//                 Not counted as a bubble.
//    2 ex_hold -> all registers keep value. stall=0. The upstream is frozen by ex_hold directly.
//    3 stall   -> bubble as in 1. bubble_count += 1, saturating at 2^CNT_W-1.
//    4 else    -> load all fields. ex_valid = id_valid.
//                 If id_valid=0, control outs load as 0 regardless of control_* inputs.
//  - Bubble guarantee: ex_valid=0 implies ex_reg_write=ex_mem_write=ex_mem_read=ex_branch=0.
//  - Decoder x on mem_to_reg (sw/beq) is registered as 0, so outputs are never x.
//  - Latency: 1 cycle ID->EX. A stall lasts exactly 1 cycle, because the load advances to MEM.
//  - Reset mid-operation dominates everything; in-flight instruction is discarded.
// STRUCTURE
//  - Shared package core_pkg: ctrl_t packed struct (branch, mem_read, mem_to_reg, alu_op[1:0],
//    mem_write, alu_src, reg_write); ALU_OP_ADD/SUB/FUNCT localparams; opcode localparams
//    OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH.
//  - Stage registers ctrl_t internally; ports stay flat.
//  - Sub-module: load_use_hazard (purely combinational stall equation). Stage regs and counter stay here.
// TESTING
//  1 Reset: assert rst mid-clock with ex_valid=1 -> all outputs 0 immediately, before next edge.
//  2 Pass-through: R-type, rs1=3 rs2=4 rd=5, alu_op=10 -> next cycle ex_rd=5, ex_alu_op=10,
//    ex_reg_write=1, ex_valid=1.
//  3 Load-use: lw x5 in EX, add x6,x5,x1 in ID -> stall=1 one cycle, EX gets bubble,
//    bubble_count=1, then add enters EX.
//  4 x0 and no-dependency: lw x0 then add using x0; lw x5 then add x6,x1,x2 -> stall=0 both cases.
//  5 Flush vs stall: load-use condition with flush=1 -> stall=0, EX bubble, bubble_count unchanged.
//  6 Hold: ex_hold=1 for 3 cycles with new ID data -> ex_* unchanged; a load-use pending in the
//    same window waits and stalls only after hold drops. Counter saturation: force CNT_W=2,
//    5 bubbles -> count=3.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: decoder control bundle, ALU op encodings, opcodes.
package core_pkg;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/load_use_hazard.sv
// Combinational load-use detector between the ID instruction and a load sitting in EX.
module load_use_hazard (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       flush,
  input  logic       ex_hold,
  output logic       stall
);

  logic rd_match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    rd_match = (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    stall    = id_valid & ex_valid & ex_mem_read & rd_match & ~flush & ~ex_hold;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, downstream hold and bubble count.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_b5,
  input  logic             control_branch,
  input  logic             control_mem_read,
  input  logic             control_mem_to_reg,
  input  logic             control_mem_write,
  input  logic             control_alu_src,
  input  logic             control_reg_write,
  input  logic [1:0]       control_alu_op,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7_b5,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic [1:0]       ex_alu_op,
  output logic [CNT_W-1:0] bubble_count
);

  ctrl_t ctrl_in;
  ctrl_t ex_ctrl;

  // mem_to_reg only matters for loads; gating with mem_read turns the decoder's
  // don't-care (x on stores/branches) into a clean 0.
  always_comb begin
    ctrl_in            = '0;
    ctrl_in.branch     = control_branch;
    ctrl_in.mem_read   = control_mem_read;
    ctrl_in.mem_to_reg = control_mem_to_reg & control_mem_read;
    ctrl_in.alu_op     = control_alu_op;
    ctrl_in.mem_write  = control_mem_write;
    ctrl_in.alu_src    = control_alu_src;
    ctrl_in.reg_write  = control_reg_write;
  end

  load_use_hazard u_hazard (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .flush       (flush),
    .ex_hold     (ex_hold),
    .stall       (stall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= '0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      ex_funct7_b5 <= 1'b0;
      bubble_count <= '0;
    end else if (ex_hold && !flush) begin
      // Frozen: every register keeps its value.
    end else if (flush || stall) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= '0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      ex_funct7_b5 <= 1'b0;
      if (!flush && bubble_count != '1) begin
        bubble_count <= bubble_count + 1'b1;
      end
    end else begin
      ex_valid     <= id_valid;
      ex_ctrl      <= id_valid ? ctrl_in : '0;
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_funct3    <= id_funct3;
      ex_funct7_b5 <= id_funct7_b5;
    end
  end

  always_comb begin
    ex_branch     = ex_ctrl.branch;
    ex_mem_read   = ex_ctrl.mem_read;
    ex_mem_to_reg = ex_ctrl.mem_to_reg;
    ex_alu_op     = ex_ctrl.alu_op;
    ex_mem_write  = ex_ctrl.mem_write;
    ex_alu_src    = ex_ctrl.alu_src;
    ex_reg_write  = ex_ctrl.reg_write;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with CNT_W=2 shares stimulus to exercise saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7_b5;
  logic        c_branch, c_mem_read, c_mem_to_reg, c_mem_write, c_alu_src, c_reg_write;
  logic [1:0]  c_alu_op;
  logic        flush, ex_hold;

  logic        stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7_b5, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write;
  logic        ex_alu_src, ex_reg_write;
  logic [1:0]  ex_alu_op;
  logic [15:0] bubble_count;

  logic        s_stall, s_ex_valid;
  logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
  logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [2:0]  s_ex_funct3;
  logic        s_ex_funct7_b5, s_ex_branch, s_ex_mem_read, s_ex_mem_to_reg, s_ex_mem_write;
  logic        s_ex_alu_src, s_ex_reg_write;
  logic [1:0]  s_ex_alu_op;
  logic [1:0]  s_bubble_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_b5(id_funct7_b5), .control_branch(c_branch), .control_mem_read(c_mem_read),
    .control_mem_to_reg(c_mem_to_reg), .control_mem_write(c_mem_write),
    .control_alu_src(c_alu_src), .control_reg_write(c_reg_write), .control_alu_op(c_alu_op),
    .flush(flush), .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7_b5(ex_funct7_b5), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op), .bubble_count(bubble_count)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_b5(id_funct7_b5), .control_branch(c_branch), .control_mem_read(c_mem_read),
    .control_mem_to_reg(c_mem_to_reg), .control_mem_write(c_mem_write),
    .control_alu_src(c_alu_src), .control_reg_write(c_reg_write), .control_alu_op(c_alu_op),
    .flush(flush), .ex_hold(ex_hold), .stall(s_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
    .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
    .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_funct3(s_ex_funct3),
    .ex_funct7_b5(s_ex_funct7_b5), .ex_branch(s_ex_branch), .ex_mem_read(s_ex_mem_read),
    .ex_mem_to_reg(s_ex_mem_to_reg), .ex_mem_write(s_ex_mem_write), .ex_alu_src(s_ex_alu_src),
    .ex_reg_write(s_ex_reg_write), .ex_alu_op(s_ex_alu_op), .bubble_count(s_bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID instruction; loads get mem_to_reg/alu_src, everything else is R-type style.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic is_load, input logic [31:0] pc);
    id_valid     = v;
    id_pc        = pc;
    id_rs1_data  = 32'h1000 + {27'd0, rs1};
    id_rs2_data  = 32'h2000 + {27'd0, rs2};
    id_imm       = is_load ? 32'd8 : 32'd0;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_funct3    = is_load ? 3'b010 : 3'b000;
    id_funct7_b5 = 1'b0;
    c_branch     = 1'b0;
    c_mem_read   = is_load;
    c_mem_to_reg = is_load;
    c_mem_write  = 1'b0;
    c_alu_src    = is_load;
    c_reg_write  = 1'b1;
    c_alu_op     = is_load ? 2'b00 : 2'b10;
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_ctrl"}, {25'd0, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
                         ex_alu_src, ex_reg_write, ex_alu_op[1]}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ex_hold = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    step();
    step();
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_count", {16'd0, bubble_count}, 32'd0);
    chk("reset_rd", {27'd0, ex_rd}, 32'd0);
    rst = 1'b0;

    // Pass-through of an R-type add x5,x3,x4 with funct-decoded ALU op
    drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 32'h100);
    id_funct7_b5 = 1'b1;
    chk("rtype_nostall", {31'd0, stall}, 32'd0);
    step();
    chk("pass_rd", {27'd0, ex_rd}, 32'd5);
    chk("pass_alu_op", {30'd0, ex_alu_op}, 32'd2);
    chk("pass_reg_write", {31'd0, ex_reg_write}, 32'd1);
    chk("pass_valid", {31'd0, ex_valid}, 32'd1);
    chk("pass_pc", ex_pc, 32'h100);
    chk("pass_rs1_data", ex_rs1_data, 32'h1003);
    chk("pass_f7", {31'd0, ex_funct7_b5}, 32'd1);

    // Load-use: lw x5 then add x6,x5,x1
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 32'h104);
    chk("lw_nostall", {31'd0, stall}, 32'd0);
    step();
    chk("lw_mem_read", {31'd0, ex_mem_read}, 32'd1);
    chk("lw_mem_to_reg", {31'd0, ex_mem_to_reg}, 32'd1);
    chk("lw_imm", ex_imm, 32'd8);
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b0, 32'h108);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    step();
    chk_bubble("lu_bubble");
    chk("lu_count", {16'd0, bubble_count}, 32'd1);
    chk("lu_stall_once", {31'd0, stall}, 32'd0);
    step();
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_rd", {27'd0, ex_rd}, 32'd6);
    chk("lu_add_rs1", {27'd0, ex_rs1}, 32'd5);

    // x0 never hazards
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 32'h10c);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 32'h110);
    chk("x0_nostall", {31'd0, stall}, 32'd0);
    step();
    // Independent add after lw x5
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 32'h114);
    step();
    drive(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 32'h118);
    chk("nodep_nostall", {31'd0, stall}, 32'd0);
    step();
    chk("nodep_rd", {27'd0, ex_rd}, 32'd6);
    chk("nodep_valid", {31'd0, ex_valid}, 32'd1);

    // Flush beats stall and does not count
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 32'h11c);
    step();
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b0, 32'h120);
    flush = 1'b1;
    #1;
    chk("flush_nostall", {31'd0, stall}, 32'd0);
    step();
    flush = 1'b0;
    chk_bubble("flush_bubble");
    chk("flush_count", {16'd0, bubble_count}, 32'd1);

    // Hold with a pending load-use in the window
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 32'h124);
    step();
    ex_hold = 1'b1;
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b0, 32'h128);
    for (int i = 0; i < 3; i++) begin
      chk("hold_nostall", {31'd0, stall}, 32'd0);
      step();
      chk("hold_rd", {27'd0, ex_rd}, 32'd5);
      chk("hold_pc", ex_pc, 32'h124);
      chk("hold_mem_read", {31'd0, ex_mem_read}, 32'd1);
    end
    chk("hold_count", {16'd0, bubble_count}, 32'd1);
    ex_hold = 1'b0;
    #1;
    chk("post_hold_stall", {31'd0, stall}, 32'd1);
    step();
    chk_bubble("post_hold_bubble");
    chk("post_hold_count", {16'd0, bubble_count}, 32'd2);
    step();
    chk("post_hold_add_pc", ex_pc, 32'h128);

    // Three more load-use bubbles: 5 total, narrow counter saturates at 3
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 32'h200);
      step();
      drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b0, 32'h204);
      step();
      step();
    end
    chk("count_five", {16'd0, bubble_count}, 32'd5);
    chk("count_sat", {30'd0, s_bubble_count}, 32'd3);

    // Invalid ID instruction loads controls as 0
    drive(1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 32'h300);
    step();
    chk_bubble("invalid_id");

    // Async reset mid-cycle with a valid instruction in EX
    drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b0, 32'h304);
    step();
    chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_bubble("async_rst");
    chk("async_rst_rd", {27'd0, ex_rd}, 32'd0);
    chk("async_rst_pc", ex_pc, 32'd0);
    chk("async_rst_count", {16'd0, bubble_count}, 32'd0);
    chk("async_rst_sat", {30'd0, s_bubble_count}, 32'd0);
    step();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
